// File: rtl/stack_core.sv
// stack_core -- small accumulator-less stack machine core.
//
// Instruction word (insn, addressed by pc):
//   [15] imm   [14] jz   [13:12] load   [11] rd   [10] wr
//   [9]  pop   [8]  push [7:0]   imm8
//
// Each instruction runs EXEC -> (MEM) -> WB. EXEC decodes and evaluates the
// ALU, MEM holds a data-memory request until mem_ready, and WB updates the
// operand stack and pc. insn == 16'hFFFF halts the core until reset.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   insn          instruction word at pc
//   pc            program counter
//   mem_addr      data memory address (low AW bits of the ALU result)
//   mem_rd/mem_wr read/write request, only ever high in MEM
//   mem_ready     memory completes the current request this cycle
//   rd_data       read data, captured when mem_ready is high in MEM
//   wr_data       write data (s0 for immediate forms, else s1)
//   halted        core stopped on the halt instruction
//   fault         stack overflow/underflow detected
//
// Build option: define STACK_CHECK_EN to trap stack overflow/underflow in a
// FAULT state. Without it, fault is tied low, the entry count saturates,
// the bottom entry is dropped on overflow and zero is shifted in on
// underflow.

module stack_core #(
  parameter int unsigned DW     = 8,
  parameter int unsigned SDEPTH = 16,
  parameter int unsigned PCW    = 10,
  parameter int unsigned AW     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    insn,
  output logic [PCW-1:0] pc,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_rd,
  output logic           mem_wr,
  input  logic           mem_ready,
  input  logic [DW-1:0]  rd_data,
  output logic [DW-1:0]  wr_data,
  output logic           halted,
  output logic           fault
);

  localparam int unsigned CW = $clog2(SDEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(SDEPTH);

  typedef enum logic [2:0] {
    EXEC,
    MEM,
    WB,
    HALT,
    FAULT
  } state_t;

  state_t          state;
  logic [DW-1:0]   stk [SDEPTH];
  logic [CW-1:0]   cnt;

  // Fields of the instruction in flight, latched in EXEC.
  logic            ir_jz;
  logic [1:0]      ir_load;
  logic            ir_push;
  logic            ir_pop;
  logic [7:0]      ir_imm8;
  logic [DW-1:0]   alu_q;
  logic [DW-1:0]   rdat_q;

  logic [DW-1:0]   alu;
  logic [DW-1:0]   top_val;
  logic [PCW-1:0]  jz_off;
  logic            grow;
  logic            shrink;
  logic            take_jump;

  // ALU evaluated from the instruction presented in EXEC; the stack does not
  // change before WB, so the latched result is still valid there.
  always_comb begin
    alu = '0;
    if (insn[15]) begin
      alu = DW'(insn[7:0]);
    end else begin
      case (insn[7:0])
        8'h00:   alu = stk[0];
        8'h01:   alu = stk[1];
        8'h02:   alu = stk[0] + stk[1];
        8'h03:   alu = stk[0] - stk[1];
        8'h04:   alu = stk[0] * stk[1];
        8'h05:   alu = stk[0] & stk[1];
        8'h06:   alu = stk[0] | stk[1];
        8'h07:   alu = stk[0] ^ stk[1];
        8'h08:   alu = stk[0] << 1;
        8'h09:   alu = stk[0] >> 1;
        default: alu = '0;
      endcase
    end
  end

  always_comb begin
    top_val = stk[0];
    case (ir_load)
      2'd0: top_val = stk[0];
      2'd1: top_val = stk[1];
      2'd2: top_val = alu_q;
      2'd3: top_val = rdat_q;
      default: top_val = stk[0];
    endcase
  end

  assign grow      = ir_push & ~ir_pop;
  assign shrink    = ir_pop & ~ir_push;
  assign jz_off    = PCW'($signed(ir_imm8));
  assign take_jump = ir_jz && (stk[0] == '0);

`ifdef STACK_CHECK_EN
  logic stack_bad;
  assign stack_bad = (grow && (cnt == FULL)) || (shrink && (cnt == '0));
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EXEC;
      pc       <= '0;
      cnt      <= '0;
      for (int unsigned i = 0; i < SDEPTH; i++) stk[i] <= '0;
      ir_jz    <= 1'b0;
      ir_load  <= '0;
      ir_push  <= 1'b0;
      ir_pop   <= 1'b0;
      ir_imm8  <= '0;
      alu_q    <= '0;
      rdat_q   <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      wr_data  <= '0;
      halted   <= 1'b0;
`ifdef STACK_CHECK_EN
      fault    <= 1'b0;
`endif
    end else begin
      case (state)
        EXEC: begin
          if (insn == 16'hFFFF) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            ir_jz   <= insn[14];
            ir_load <= insn[13:12];
            ir_pop  <= insn[9];
            ir_push <= insn[8];
            ir_imm8 <= insn[7:0];
            alu_q   <= alu;
            if (insn[11] | insn[10]) begin
              state    <= MEM;
              mem_rd   <= insn[11];
              mem_wr   <= insn[10];
              mem_addr <= alu[AW-1:0];
              wr_data  <= insn[15] ? stk[0] : stk[1];
            end else begin
              state <= WB;
            end
          end
        end

        MEM: begin
          if (mem_ready) begin
            rdat_q <= rd_data;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            state  <= WB;
          end
        end

        WB: begin
`ifdef STACK_CHECK_EN
          if (stack_bad) begin
            state <= FAULT;
            fault <= 1'b1;
          end else
`endif
          begin
            // s0 always takes the selected value; push/pop only move the
            // entries beneath it.
            if (grow) begin
              for (int unsigned i = 1; i < SDEPTH; i++) stk[i] <= stk[i-1];
              if (cnt != FULL) cnt <= cnt + 1'b1;
            end else if (shrink) begin
              for (int unsigned i = 1; i < SDEPTH - 1; i++) stk[i] <= stk[i+1];
              stk[SDEPTH-1] <= '0;
              if (cnt != '0) cnt <= cnt - 1'b1;
            end
            stk[0] <= top_val;
            pc     <= take_jump ? pc + jz_off : pc + 1'b1;
            state  <= EXEC;
          end
        end

        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= EXEC;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_core.sv
module tb_stack_core;

  localparam int unsigned DW     = 8;
  localparam int unsigned SDEPTH = 4;
  localparam int unsigned PCW    = 10;
  localparam int unsigned AW     = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [15:0]    insn = '0;
  logic [PCW-1:0] pc;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd;
  logic           mem_wr;
  logic           mem_ready = 1'b0;
  logic [DW-1:0]  rd_data = '0;
  logic [DW-1:0]  wr_data;
  logic           halted;
  logic           fault;

  stack_core #(
    .DW     (DW),
    .SDEPTH (SDEPTH),
    .PCW    (PCW),
    .AW     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .insn      (insn),
    .pc        (pc),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ready (mem_ready),
    .rd_data   (rd_data),
    .wr_data   (wr_data),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Instruction-level reference model: the stack is a queue, front = top.
  int m_stk[$];
  int m_cnt;
  int m_pc;
  int m_rdq;
  bit m_halt;
  bit m_fault;

  int wr_cycles;
  int obs_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    repeat (SDEPTH) m_stk.push_back(0);
    m_cnt   = 0;
    m_pc    = 0;
    m_rdq   = 0;
    m_halt  = 0;
    m_fault = 0;
  endtask

  function automatic int alu_f(input logic [15:0] i, input int a, input int b);
    int m;
    m = 1 << DW;
    if (i[15]) return int'(i[7:0]);
    case (int'(i[7:0]))
      0: return a;
      1: return b;
      2: return (a + b) % m;
      3: return (a - b + m) % m;
      4: return (a * b) % m;
      5: return a & b;
      6: return a | b;
      7: return a ^ b;
      8: return (a * 2) % m;
      9: return a / 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic [15:0] i, input int rdv, input bit mem,
                            output int e_addr, output int e_wd);
    int s0, s1, r, top, off;
    bit push, pop;
    e_addr = 0;
    e_wd   = 0;
    if (i == 16'hFFFF) begin
      m_halt = 1;
      return;
    end
    s0 = m_stk[0];
    s1 = m_stk[1];
    r  = alu_f(i, s0, s1);
    e_addr = r % (1 << AW);
    e_wd   = i[15] ? s0 : s1;
    if (mem) m_rdq = rdv;
    case (i[13:12])
      2'd0: top = s0;
      2'd1: top = s1;
      2'd2: top = r;
      default: top = m_rdq;
    endcase
    push = i[8];
    pop  = i[9];
`ifdef STACK_CHECK_EN
    if ((push && !pop && m_cnt == SDEPTH) || (pop && !push && m_cnt == 0)) begin
      m_fault = 1;
      return;
    end
`endif
    off = int'(i[7:0]);
    if (off >= 128) off = off - 256;
    if (i[14] && s0 == 0) m_pc = (m_pc + off + (1 << PCW)) % (1 << PCW);
    else                  m_pc = (m_pc + 1) % (1 << PCW);
    if (push && !pop) begin
      void'(m_stk.pop_back());
      m_stk.push_front(top);
      if (m_cnt < SDEPTH) m_cnt++;
    end else if (pop && !push) begin
      void'(m_stk.pop_front());
      m_stk.push_back(0);
      m_stk[0] = top;
      if (m_cnt > 0) m_cnt--;
    end else begin
      m_stk[0] = top;
    end
  endtask

  task automatic run(input logic [15:0] i, input int waits);
    int  e_addr, e_wd, rdv;
    bit  mem;
    mem = (i != 16'hFFFF) && (i[11] || i[10]);
    rdv = int'($urandom_range(0, 255));
    model_step(i, rdv, mem, e_addr, e_wd);
    insn = i;
    @(posedge clk); #1;
    if (m_halt) begin
      chk("halted_set", halted, 1);
      chk("halt_pc", pc, m_pc);
      chk("halt_mem_idle", {mem_rd, mem_wr}, 0);
      return;
    end
    wr_cycles = 0;
    if (mem) begin
      for (int k = 0; k <= waits; k++) begin
        chk("mem_rd", mem_rd, i[11]);
        chk("mem_wr", mem_wr, i[10]);
        chk("mem_addr", mem_addr, e_addr);
        chk("wr_data", wr_data, e_wd);
        if (mem_wr) wr_cycles++;
        obs_wd = int'(wr_data);
        if (k == waits) begin
          mem_ready = 1'b1;
          rd_data   = rdv[7:0];
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
      end
    end
    chk("wb_mem_idle", {mem_rd, mem_wr}, 0);
    @(posedge clk); #1;
    chk("pc", pc, m_pc);
    chk("fault", fault, m_fault);
    chk("halted", halted, 0);
    chk("exec_mem_idle", {mem_rd, mem_wr}, 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    insn      = '0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_pc", pc, 0);
    chk("rst_mem_idle", {mem_rd, mem_wr}, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ri;
    model_reset();
    #2;
    do_reset();

    // push 5, push 3, add with pop -> 8, pc 3 after six cycles
    run(16'hA105, 0);
    run(16'hA103, 0);
    run(16'h2202, 0);
    chk("add_pc", pc, 3);
    run(16'h8440, 0);
    chk("add_s0", obs_wd, 8);

    // modulo arithmetic at DW=8
    do_reset();
    run(16'hA1C8, 0);
    run(16'hA164, 0);
    run(16'h2002, 0);
    run(16'h8440, 0);
    chk("add_wrap", obs_wd, 44);
    run(16'hA110, 0);
    run(16'hA110, 0);
    run(16'h2204, 0);
    run(16'h8440, 0);
    chk("mul_wrap", obs_wd, 0);

    // write with three wait cycles
    do_reset();
    run(16'hA15A, 0);
    run(16'h8420, 3);
    chk("wait_wr_cycles", wr_cycles, 4);
    chk("wait_wr_data", obs_wd, 8'h5A);
    chk("wait_pc", pc, 2);

    // jz taken backward and not taken
    do_reset();
    repeat (10) run(16'h0000, 0);
    run(16'h40FE, 0);
    chk("jz_taken", pc, 8);
    run(16'hA101, 0);
    run(16'h0000, 0);
    run(16'h40FE, 0);
    chk("jz_not_taken", pc, 11);

    // five pushes into a four-deep stack
    do_reset();
    repeat (5) run(16'hA107, 0);
`ifdef STACK_CHECK_EN
    chk("ovf_fault", fault, 1);
    chk("ovf_pc", pc, 4);
`else
    chk("ovf_fault", fault, 0);
    chk("ovf_pc", pc, 5);
`endif

    // halt holds pc for 20 cycles despite new instructions
    do_reset();
    repeat (3) run(16'h0000, 0);
    run(16'hFFFF, 0);
    insn = 16'hA101;
    repeat (20) begin
      @(posedge clk); #1;
      chk("halt_hold_pc", pc, 3);
      chk("halt_hold", halted, 1);
      chk("halt_hold_idle", {mem_rd, mem_wr}, 0);
    end

    // reset asserted in the middle of a read
    do_reset();
    repeat (2) run(16'hA133, 0);
    insn = 16'h0800;
    @(posedge clk); #1;
    chk("mid_mem_rd_high", mem_rd, 1);
    rst = 1'b1;
    #1;
    chk("mid_mem_rd_abort", mem_rd, 0);
    chk("mid_mem_pc", pc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run(16'h8440, 0);
    chk("mid_mem_stack_clear", obs_wd, 0);

    // randomized instruction stream
    do_reset();
    for (int n = 0; n < 300; n++) begin
      ri = 16'($urandom);
      if (ri == 16'hFFFF) ri = 16'h0000;
      run(ri, int'($urandom_range(0, 3)));
      if (m_fault) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/stack_core.md
STACK_CORE -- requirements
Module: stack_core

Interface
REQ-001 Parameter DW, default 8, data/stack word width (8..32).
REQ-002 Parameter SDEPTH, default 16, operand stack depth in entries (4..64).
REQ-003 Parameter PCW, default 10, program counter width.
REQ-004 Parameter AW, default 8, data memory address width (AW <= DW).
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 insn  in  16  instruction word addressed by pc.
REQ-008 pc  out  PCW  program counter.
REQ-009 mem_addr  out  AW  data memory address, low AW bits of ALU result.
REQ-010 mem_rd  out  1  read request.
REQ-011 mem_wr  out  1  write request.
REQ-012 mem_ready  in  1  memory completes current request this cycle.
REQ-013 rd_data  in  DW  read data, valid when mem_ready high during a read.
REQ-014 wr_data  out  DW  write data.
REQ-015 halted  out  1  core stopped on halt instruction.
REQ-016 fault  out  1  stack overflow/underflow detected (see Configuration).

Function
REQ-017 insn fields: [15] imm, [14] jz, [13:12] load, [11] rd, [10] wr, [9] pop, [8] push, [7:0] imm8.
REQ-018 ALU result: imm=1 -> imm8 zero-extended to DW; else op imm8: 00 s0, 01 s1, 02 s0+s1, 03 s0-s1, 04 low DW bits of s0*s1, 05 s0&s1, 06 s0|s1, 07 s0^s1, 08 s0<<1, 09 s0>>1 logical, others 0; all modulo 2^DW.
REQ-019 FSM states EXEC, MEM, WB, HALT, FAULT; reset state EXEC.
REQ-020 EXEC: insn==16'hFFFF -> HALT; rd or wr set -> MEM; else -> WB.
REQ-021 MEM: mem_rd=rd, mem_wr=wr, mem_addr and wr_data held stable; stay until mem_ready sampled high, then -> WB; rd_data captured that cycle.
REQ-022 wr_data = s0 when imm=1, else s1; captured on EXEC->MEM.
REQ-023 rd and wr both set: write and read issued together; rd_data captured as read.
REQ-024 WB: s0 <= {0: s0, 1: s1, 2: ALU result, 3: captured rd_data}; push&~pop shifts entries down, pop&~push shifts up, both or neither no shift; entry count updated accordingly; -> EXEC.
REQ-025 WB pc: jz=1 and pre-update s0==0 -> pc + sign-extended imm8 (modulo 2^PCW); else pc+1, wrapping at 2^PCW-1 -> 0.
REQ-026 Latency: non-memory instruction 2 cycles; memory instruction 3 cycles + wait cycles where mem_ready low.
REQ-027 HALT: halted=1, pc frozen, mem_rd=mem_wr=0, stack frozen; exits only on reset.
REQ-028 mem_rd/mem_wr never high outside MEM.

Reset
REQ-029 On rst: pc=0, all stack entries=0, entry count=0, mem_rd=mem_wr=0, wr_data=0, halted=0, fault=0, state EXEC.
REQ-030 rst mid-MEM aborts request immediately; no stack or pc update.

Configuration
REQ-031 Macro STACK_CHECK_EN defined: WB with push&~pop at count==SDEPTH, or pop&~push at count==0, -> FAULT instead of EXEC; no stack/pc update; fault=1, mem requests 0, held until reset.
REQ-032 STACK_CHECK_EN undefined: no checking; fault tied 0; count saturates at 0/SDEPTH; bottom entry discarded on overflow, zero shifted in on underflow.

Verification
REQ-033 Push imm 5, push imm 3, ALU 02 -> s0=8 at WB, pc=3 after 6 cycles.
REQ-034 DW=8: s0=200, s1=100, ALU 02 -> s0=44; ALU 04 with 16,16 -> s0=0.
REQ-035 Write imm8=0x20 with s0=0x5A, mem_ready low 3 cycles -> mem_wr high 4 cycles, mem_addr=0x20, wr_data=0x5A, pc advances once.
REQ-036 jz imm8=0xFE, s0=0 at pc=10 -> pc=8; s0=1 -> pc=11.
REQ-037 STACK_CHECK_EN, SDEPTH=4: 5 pushes -> fault=1 after 5th WB, pc=4; without macro fault=0, pc=5.
REQ-038 insn 16'hFFFF -> halted=1, pc constant 20 cycles; rst pulse in MEM -> mem_rd=0 same cycle, pc=0.
